program_loader: RTL and testbench

- Writer side of the instruction store. Accepts a byte stream over a valid/ready handshake and assembles 16-bit instructions from byte pairs.
- Issues single-cycle write strobes into program memory at incrementing addresses.
- Holds the CPU core in reset until a complete program has been loaded.
- Sits between the external boot/debug byte source and program memory. CPU reset = rst OR cpu_hold.

---
 rtl/program_loader_pkg.sv | 19 +
 rtl/program_loader.sv | 192 +++++++++++++++++++
 tb/tb_program_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and sizing for the program loader.
package program_loader_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam int ADDR_WIDTH  = 5;
  localparam int BYTE_WIDTH  = 8;
  localparam int MAX_INSTR   = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    GET_COUNT,
    GET_HI,
    GET_LO,
    WRITE,
    GET_SUM,
    FINISH
  } state_t;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles 16-bit words into program memory.
// Optional trailing XOR checksum byte with PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int INSTR_WIDTH = program_loader_pkg::INSTR_WIDTH,
  parameter int ADDR_WIDTH  = program_loader_pkg::ADDR_WIDTH,
  parameter int BYTE_WIDTH  = program_loader_pkg::BYTE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [BYTE_WIDTH-1:0]  s_data,
  output logic                   pm_we,
  output logic [ADDR_WIDTH-1:0]  pm_addr,
  output logic [INSTR_WIDTH-1:0] pm_wdata,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);
  import program_loader_pkg::*;

  localparam logic [BYTE_WIDTH:0] MAX_N = (BYTE_WIDTH+1)'(2 ** ADDR_WIDTH);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH:0]    remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BYTE_WIDTH-1:0]  hi_q, hi_d;
  logic [ADDR_WIDTH-1:0]  pm_addr_q, pm_addr_d;
  logic [INSTR_WIDTH-1:0] pm_wdata_q, pm_wdata_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   cpu_hold_q, cpu_hold_d;
  logic                   xfer;
  logic                   bad_count;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0]  sum_q, sum_d;
`endif

  always_comb begin
    s_ready = (state_q == GET_COUNT) ||
              (state_q == GET_HI) ||
              (state_q == GET_LO);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    s_ready = s_ready || (state_q == GET_SUM);
`endif
  end

  assign xfer      = s_valid && s_ready;
  assign bad_count = (s_data == '0) || ({1'b0, s_data} > MAX_N);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    hi_d        = hi_q;
    pm_addr_d   = pm_addr_q;
    pm_wdata_d  = pm_wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    cpu_hold_d  = cpu_hold_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          cpu_hold_d = 1'b1;
          state_d    = GET_COUNT;
        end
      end
      GET_COUNT: begin
        if (xfer) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d = s_data;
`endif
          if (bad_count) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            remaining_d = (ADDR_WIDTH+1)'(s_data);
            addr_d      = '0;
            state_d     = GET_HI;
          end
        end
      end
      GET_HI: begin
        if (xfer) begin
          hi_d    = s_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = sum_q ^ s_data;
`endif
          state_d = GET_LO;
        end
      end
      GET_LO: begin
        if (xfer) begin
          pm_addr_d  = addr_q;
          pm_wdata_d = {hi_q, s_data};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d      = sum_q ^ s_data;
`endif
          state_d    = WRITE;
        end
      end
      WRITE: begin
        addr_d      = addr_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = GET_SUM;
`else
          state_d = FINISH;
`endif
        end else begin
          state_d = GET_HI;
        end
      end
      GET_SUM: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (xfer) begin
          if (s_data == sum_q) begin
            state_d = FINISH;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      FINISH: begin
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      hi_q        <= '0;
      pm_addr_q   <= '0;
      pm_wdata_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_hold_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      hi_q        <= hi_d;
      pm_addr_q   <= pm_addr_d;
      pm_wdata_q  <= pm_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_hold_q  <= cpu_hold_d;
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end
`endif

  assign pm_we    = (state_q == WRITE);
  assign pm_addr  = pm_addr_q;
  assign pm_wdata = pm_wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader (byte driver, write monitor).
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        pm_we;
  logic [4:0]  pm_addr;
  logic [15:0] pm_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  program_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .pm_we    (pm_we),
    .pm_addr  (pm_addr),
    .pm_wdata (pm_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  typedef struct {
    logic [4:0]  a;
    logic [15:0] d;
  } wr_t;

  logic [7:0] tx_q[$];
  wr_t        exp_q[$];
  int         n_chk;
  int         n_pass;
  int         we_cnt;
  bit         tog;
  bit         tog_ph;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam int SUM_EXTRA = 1;
`else
  localparam int SUM_EXTRA = 0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  // Byte source: present head of queue, pop when the edge will take it.
  always @(negedge clk) begin
    if (tog && tog_ph) begin
      s_valid = 1'b0;
    end else if (tx_q.size() > 0) begin
      s_valid = 1'b1;
      s_data  = tx_q[0];
    end else begin
      s_valid = 1'b0;
    end
    if (tog) tog_ph = ~tog_ph;
    if (s_valid && s_ready) void'(tx_q.pop_front());
  end

  always @(negedge clk) begin
    wr_t e;
    if (pm_we) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        chk("we_unexpected", 32'(pm_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("we_addr", 32'(pm_addr), 32'(e.a));
        chk("we_data", 32'(pm_wdata), 32'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic push_prog(input logic [7:0] sum);
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h12);
    tx_q.push_back(8'h34);
    tx_q.push_back(8'hAB);
    tx_q.push_back(8'hCD);
    if (SUM_EXTRA != 0) tx_q.push_back(sum);
    exp_q.push_back('{a: 5'd0, d: 16'h1234});
    exp_q.push_back('{a: 5'd1, d: 16'hABCD});
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    we_cnt  = 0;
    tog     = 1'b0;
    tog_ph  = 1'b0;
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (2) tick();
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_we", 32'(pm_we), 32'd0);
    chk("rst_addr", 32'(pm_addr), 32'd0);
    chk("rst_wdata", 32'(pm_wdata), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;

    // Basic load with exact 3N+3 latency
    we_cnt = 0;
    push_prog(8'h42);
    do_start();
    chk("busy_on", 32'(busy), 32'd1);
    repeat (7 + SUM_EXTRA) tick();
    chk("done_early", 32'(done), 32'd0);
    tick();
    chk("done_3n3", 32'(done), 32'd1);
    chk("hold_rel", 32'(cpu_hold), 32'd0);
    chk("busy_off", 32'(busy), 32'd0);
    chk("err_ok", 32'(error), 32'd0);
    chk("we_cnt2", 32'(we_cnt), 32'd2);
    chk("sb_empty1", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
    chk("done_sticky", 32'(done), 32'd1);

    // Count of zero and over-range count
    for (int k = 0; k < 2; k++) begin
      logic [7:0] cnt;
      cnt = (k == 0) ? 8'h00 : 8'h21;
      we_cnt = 0;
      tx_q.push_back(cnt);
      do_start();
      chk("restart_hold", 32'(cpu_hold), 32'd1);
      wait_idle(20);
      chk("badcnt_err", 32'(error), 32'd1);
      chk("badcnt_done", 32'(done), 32'd0);
      chk("badcnt_hold", 32'(cpu_hold), 32'd1);
      repeat (3) tick();
      chk("badcnt_we", 32'(we_cnt), 32'd0);
    end

    // Valid toggling every cycle
    we_cnt = 0;
    tog    = 1'b1;
    push_prog(8'h42);
    do_start();
    wait_idle(60);
    tog = 1'b0;
    chk("tog_done", 32'(done), 32'd1);
    chk("tog_we", 32'(we_cnt), 32'd2);
    chk("tog_sb", 32'(exp_q.size()), 32'd0);
    chk("tog_tx", 32'(tx_q.size()), 32'd0);

    // Reset one cycle after first write
    we_cnt = 0;
    push_prog(8'h42);
    void'(exp_q.pop_back());
    do_start();
    for (int n = 0; n < 20 && we_cnt == 0; n++) tick();
    chk("mid_we1", 32'(we_cnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_q.delete();
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_hold", 32'(cpu_hold), 32'd1);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_err", 32'(error), 32'd0);
    repeat (6) tick();
    chk("mid_nowe", 32'(we_cnt), 32'd1);
    we_cnt = 0;
    tx_q.push_back(8'h01);
    tx_q.push_back(8'hBE);
    tx_q.push_back(8'hEF);
    if (SUM_EXTRA != 0) tx_q.push_back(8'h50);
    exp_q.push_back('{a: 5'd0, d: 16'hBEEF});
    do_start();
    wait_idle(40);
    chk("beef_done", 32'(done), 32'd1);
    chk("beef_we", 32'(we_cnt), 32'd1);

    // Start pulsed while busy
    we_cnt = 0;
    push_prog(8'h42);
    do_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(40);
    chk("sbusy_done", 32'(done), 32'd1);
    chk("sbusy_err", 32'(error), 32'd0);
    chk("sbusy_we", 32'(we_cnt), 32'd2);
    chk("sbusy_sb", 32'(exp_q.size()), 32'd0);

    // rst and start together: rst wins
    tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_wins", 32'(busy), 32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    we_cnt = 0;
    push_prog(8'h43);
    do_start();
    wait_idle(40);
    chk("sum_err", 32'(error), 32'd1);
    chk("sum_done", 32'(done), 32'd0);
    chk("sum_hold", 32'(cpu_hold), 32'd1);
    chk("sum_we", 32'(we_cnt), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
